// File: rtl/gp_reg_file_pkg.sv
// Shared definitions for the general-purpose register file: operation
// encoding and the read-select width helper.
package gp_reg_file_pkg;

    localparam logic [2:0] FS_CLEAR = 3'b000;
    localparam logic [2:0] FS_LOAD  = 3'b001;
    localparam logic [2:0] FS_DEC   = 3'b010;
    localparam logic [2:0] FS_INC   = 3'b011;
    localparam logic [2:0] FS_LOADL = 3'b100;
    localparam logic [2:0] FS_LOADH = 3'b101;
    localparam logic [2:0] FS_SHL   = 3'b110;
    localparam logic [2:0] FS_SHR   = 3'b111;

    // ceil(log2(n)), never less than 1 so a single-entry file still has a select bit
    function automatic int sel_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 30; i++) begin
            if ((32'sd1 <<< i) < n) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/gp_reg_file_rf_cell.sv
// One register of the file: applies the shared operation when enabled and
// flags when an inc/dec reaches the all-ones / zero boundary.
module rf_cell
    import gp_reg_file_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       fun_sel,
    input  logic             sat_mode,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             bnd
);

    localparam int H = WIDTH / 2;

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] nxt_s;
    logic             hit_s;

    // next-state and boundary detection for the selected operation
    always_comb begin
        nxt_s = q_r;
        hit_s = 1'b0;
        case (fun_sel)
            FS_CLEAR: nxt_s = {WIDTH{1'b0}};
            FS_LOAD:  nxt_s = din;
            FS_DEC: begin
                if (q_r == {WIDTH{1'b0}}) begin
                    hit_s = 1'b1;
                    nxt_s = sat_mode ? q_r : {WIDTH{1'b1}};
                end else begin
                    nxt_s = q_r - {{(WIDTH-1){1'b0}}, 1'b1};
                end
            end
            FS_INC: begin
                if (q_r == {WIDTH{1'b1}}) begin
                    hit_s = 1'b1;
                    nxt_s = sat_mode ? q_r : {WIDTH{1'b0}};
                end else begin
                    nxt_s = q_r + {{(WIDTH-1){1'b0}}, 1'b1};
                end
            end
            FS_LOADL: nxt_s = {q_r[WIDTH-1:H], din[H-1:0]};
            FS_LOADH: nxt_s = {din[H-1:0], q_r[H-1:0]};
            FS_SHL:   nxt_s = {q_r[WIDTH-2:0], 1'b0};
            FS_SHR:   nxt_s = {1'b0, q_r[WIDTH-1:1]};
            default:  nxt_s = q_r;
        endcase
    end

    // register state; reset discards any pending update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= {WIDTH{1'b0}};
        end else if (en) begin
            q_r <= nxt_s;
        end else begin
            q_r <= q_r;
        end
    end

    assign q   = q_r;
    assign bnd = en & hit_s;

endmodule

// File: rtl/gp_reg_file.sv
// General-purpose register file: NT temporaries then NR general registers,
// two combinational read ports and a registered inc/dec boundary flag.
module gp_reg_file
    import gp_reg_file_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NR    = 4,
    parameter  int NT    = 4,
    localparam int SELW  = sel_width(NT + NR)
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] Input,
    input  logic [2:0]       FunSel,
    input  logic [NR-1:0]    RSel,
    input  logic [NT-1:0]    TSel,
    input  logic             SatMode,
    input  logic [SELW-1:0]  O1Sel,
    input  logic [SELW-1:0]  O2Sel,
    output logic [WIDTH-1:0] Output1,
    output logic [WIDTH-1:0] Output2,
    output logic             OvfFlag
);

    localparam int NREG = NT + NR;

    logic [WIDTH-1:0] regs_s [NREG];
    logic [NREG-1:0]  bnd_s;
    logic [WIDTH-1:0] rd1_s;
    logic [WIDTH-1:0] rd2_s;
    logic             ovf_r;

    // index 0..NT-1 are T1..T<NT>, index NT.. are R1..R<NR>
    for (genvar i = 0; i < NT; i++) begin : g_t
        rf_cell #(.WIDTH(WIDTH)) u_cell (
            .clk      (Clock),
            .rst_n    (Reset_n),
            .en       (TSel[i]),
            .fun_sel  (FunSel),
            .sat_mode (SatMode),
            .din      (Input),
            .q        (regs_s[i]),
            .bnd      (bnd_s[i])
        );
    end

    for (genvar i = 0; i < NR; i++) begin : g_r
        rf_cell #(.WIDTH(WIDTH)) u_cell (
            .clk      (Clock),
            .rst_n    (Reset_n),
            .en       (RSel[i]),
            .fun_sel  (FunSel),
            .sat_mode (SatMode),
            .din      (Input),
            .q        (regs_s[NT + i]),
            .bnd      (bnd_s[NT + i])
        );
    end

    // AND-OR read muxes; out-of-range selects match nothing and read zero
    always_comb begin
        rd1_s = {WIDTH{1'b0}};
        rd2_s = {WIDTH{1'b0}};
        for (int k = 0; k < NREG; k++) begin
            rd1_s = rd1_s | (regs_s[k] & {WIDTH{O1Sel == SELW'(k)}});
            rd2_s = rd2_s | (regs_s[k] & {WIDTH{O2Sel == SELW'(k)}});
        end
    end

    // one-cycle boundary flag from any enabled cell
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= |bnd_s;
        end
    end

    assign Output1 = rd1_s;
    assign Output2 = rd2_s;
    assign OvfFlag = ovf_r;

endmodule

// File: tb/tb_gp_reg_file.sv
// Directed scoreboard bench for gp_reg_file: default 8-bit instance plus a
// 16-bit / NR=8 / NT=2 instance for wider data and out-of-range selects.
module tb_gp_reg_file;
    import gp_reg_file_pkg::*;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t sb [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic clk = 1'b0;
    logic rst_n;

    logic [7:0]  a_in;
    logic [2:0]  a_fun;
    logic [3:0]  a_rsel;
    logic [3:0]  a_tsel;
    logic        a_sat;
    logic [2:0]  a_o1;
    logic [2:0]  a_o2;
    logic [7:0]  a_out1;
    logic [7:0]  a_out2;
    logic        a_ovf;

    logic [15:0] b_in;
    logic [2:0]  b_fun;
    logic [7:0]  b_rsel;
    logic [1:0]  b_tsel;
    logic        b_sat;
    logic [3:0]  b_o1;
    logic [3:0]  b_o2;
    logic [15:0] b_out1;
    logic [15:0] b_out2;
    logic        b_ovf;

    always #5 clk = ~clk;

    gp_reg_file u_dut_a (
        .Clock(clk), .Reset_n(rst_n), .Input(a_in), .FunSel(a_fun),
        .RSel(a_rsel), .TSel(a_tsel), .SatMode(a_sat),
        .O1Sel(a_o1), .O2Sel(a_o2),
        .Output1(a_out1), .Output2(a_out2), .OvfFlag(a_ovf)
    );

    gp_reg_file #(.WIDTH(16), .NR(8), .NT(2)) u_dut_b (
        .Clock(clk), .Reset_n(rst_n), .Input(b_in), .FunSel(b_fun),
        .RSel(b_rsel), .TSel(b_tsel), .SatMode(b_sat),
        .O1Sel(b_o1), .O2Sel(b_o2),
        .Output1(b_out1), .Output2(b_out2), .OvfFlag(b_ovf)
    );

    task automatic push(input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [15:0] obs);
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty observed=%h expected=<scoreboard entry>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_rsel = 4'b0000;
        a_tsel = 4'b0000;
        b_rsel = 8'h00;
        b_tsel = 2'b00;
    endtask

    initial begin
        rst_n = 1'b0;
        a_in = 8'h00; a_fun = FS_CLEAR; a_rsel = 4'b0000; a_tsel = 4'b0000;
        a_sat = 1'b0; a_o1 = 3'd0; a_o2 = 3'd0;
        b_in = 16'h0000; b_fun = FS_CLEAR; b_rsel = 8'h00; b_tsel = 2'b00;
        b_sat = 1'b0; b_o1 = 4'd0; b_o2 = 4'd0;
        #1;

        // reset state on every valid select
        push("rst_ovf", 16'h0000);
        chk({15'b0, a_ovf});
        for (int k = 0; k < 8; k++) begin
            a_o1 = 3'(k);
            a_o2 = 3'(7 - k);
            #1;
            push("rst_o1", 16'h0000);
            push("rst_o2", 16'h0000);
            chk({8'h00, a_out1});
            chk({8'h00, a_out2});
        end
        #3 rst_n = 1'b1;
        step();

        // load R1, read through both ports
        a_fun = FS_LOAD; a_rsel = 4'b0001; a_in = 8'hA5;
        a_o1 = 3'd4; a_o2 = 3'd0;
        push("r1_load_o1", 16'h00A5);
        push("t1_zero_o2", 16'h0000);
        step(); idle();
        chk({8'h00, a_out1});
        chk({8'h00, a_out2});
        a_o2 = 3'd4; #1;
        push("r1_load_o2", 16'h00A5);
        chk({8'h00, a_out2});

        // plain increment: no boundary
        a_fun = FS_INC; a_rsel = 4'b0001;
        push("r1_inc", 16'h00A6);
        push("r1_inc_ovf", 16'h0000);
        step(); idle();
        chk({8'h00, a_out1});
        chk({15'b0, a_ovf});

        // R2 wrapping then saturating increment of 0xFF
        a_o1 = 3'd5;
        a_fun = FS_LOAD; a_rsel = 4'b0010; a_in = 8'hFF;
        step();
        a_fun = FS_INC; a_sat = 1'b0;
        push("r2_inc_wrap", 16'h0000);
        push("r2_wrap_ovf", 16'h0001);
        push("ovf_clears", 16'h0000);
        step(); idle();
        chk({8'h00, a_out1});
        chk({15'b0, a_ovf});
        step();
        chk({15'b0, a_ovf});
        a_fun = FS_LOAD; a_rsel = 4'b0010; a_in = 8'hFF;
        step();
        a_fun = FS_INC; a_sat = 1'b1;
        push("r2_inc_sat", 16'h00FF);
        push("r2_sat_ovf", 16'h0001);
        step(); idle();
        chk({8'h00, a_out1});
        chk({15'b0, a_ovf});

        // R3 decrement of 0: saturating holds, wrapping goes all-ones
        a_o1 = 3'd6;
        a_fun = FS_DEC; a_rsel = 4'b0100; a_sat = 1'b1;
        push("r3_dec_sat", 16'h0000);
        push("r3_dsat_ovf", 16'h0001);
        step();
        chk({8'h00, a_out1});
        chk({15'b0, a_ovf});
        a_sat = 1'b0;
        push("r3_dec_wrap", 16'h00FF);
        push("r3_dwrap_ovf", 16'h0001);
        step();
        chk({8'h00, a_out1});
        chk({15'b0, a_ovf});
        push("r3_dec_norm", 16'h00FE);
        push("r3_dnorm_ovf", 16'h0000);
        step(); idle();
        chk({8'h00, a_out1});
        chk({15'b0, a_ovf});

        // T3 half loads then shift left
        a_o1 = 3'd2; a_o2 = 3'd2;
        a_fun = FS_LOAD; a_tsel = 4'b0100; a_in = 8'h3C;
        step();
        a_fun = FS_LOADH; a_in = 8'h07;
        push("t3_loadh", 16'h007C);
        step();
        chk({8'h00, a_out1});
        a_fun = FS_LOADL; a_in = 8'h0E;
        push("t3_loadl", 16'h007E);
        step();
        chk({8'h00, a_out2});
        a_fun = FS_SHL;
        push("t3_shl", 16'h00FC);
        step(); idle();
        chk({8'h00, a_out1});

        // broadcast load then shift right on all eight registers
        a_fun = FS_LOAD; a_rsel = 4'b1111; a_tsel = 4'b1111; a_in = 8'h81;
        step();
        a_fun = FS_SHR;
        push("all_shr_ovf", 16'h0000);
        step(); idle();
        chk({15'b0, a_ovf});
        for (int k = 0; k < 8; k++) begin
            a_o1 = 3'(k);
            a_o2 = 3'(7 - k);
            #1;
            push("all_shr_o1", 16'h0040);
            push("all_shr_o2", 16'h0040);
            chk({8'h00, a_out1});
            chk({8'h00, a_out2});
        end

        // clear only R1, neighbour R2 holds
        a_fun = FS_CLEAR; a_rsel = 4'b0001;
        a_o1 = 3'd4; a_o2 = 3'd5;
        push("r1_clear", 16'h0000);
        push("r2_hold", 16'h0040);
        step(); idle();
        chk({8'h00, a_out1});
        chk({8'h00, a_out2});

        // reset pulse between edges during an increment of R4
        a_o1 = 3'd7;
        a_fun = FS_LOAD; a_rsel = 4'b1000; a_in = 8'h10;
        step();
        a_fun = FS_INC;
        #2 rst_n = 1'b0;
        #1;
        push("r4_async_rst", 16'h0000);
        chk({8'h00, a_out1});
        #1 rst_n = 1'b1;
        idle();
        step();
        push("r4_after_rst", 16'h0000);
        push("r4_rst_ovf", 16'h0000);
        chk({8'h00, a_out1});
        chk({15'b0, a_ovf});

        // wide instance: R1 at index 2, R8 at index 9, 10..15 out of range
        b_fun = FS_LOAD; b_rsel = 8'h01; b_in = 16'h1234;
        step(); idle();
        b_o1 = 4'd2; #1;
        push("b_r1_load", 16'h1234);
        chk(b_out1);
        b_fun = FS_LOAD; b_rsel = 8'h80; b_in = 16'hBEEF;
        step(); idle();
        b_o2 = 4'd9; #1;
        push("b_r8_load", 16'hBEEF);
        chk(b_out2);
        b_o1 = 4'd10; #1;
        push("b_sel10_zero", 16'h0000);
        chk(b_out1);
        b_o1 = 4'd15; #1;
        push("b_sel15_zero", 16'h0000);
        chk(b_out1);
        b_fun = FS_LOADH; b_rsel = 8'h01; b_in = 16'hFF5A;
        step(); idle();
        b_o1 = 4'd2; #1;
        push("b_r1_loadh", 16'h5A34);
        chk(b_out1);

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end else begin
            n_tests++;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
